axis_inst_loader: RTL and testbench

Hardware instruction loader at INST_LOADER node; replaces the bench-side instruction injection task.
- Host writes 32-bit MVM instructions, each tagged with a destination node, into an internal buffer.
- On `start`, the whole program streams into the mesh `axis_in_*` port of its node as single-flit AXI-S packets.
- Runs on `clk` (user clock domain), upstream of axis_mesh and the MVM instruction memories.

---
 rtl/axis_inst_loader.sv | 217 +++++++++++++++++++++
 tb/tb_axis_inst_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_inst_loader.sv
// Instruction loader: buffers host-written MVM instructions and streams them as single-flit AXI-S packets.
// Optional feature macro INST_LOADER_REPLAY_EN: keep the program and re-send it on every start.
module axis_inst_loader #(
    parameter int unsigned DATAW     = 512,
    parameter int unsigned USERW     = 75,
    parameter int unsigned IDW       = 2,
    parameter int unsigned DESTW     = 4,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned TID       = 0,
    parameter logic [1:0]  INST_TYPE = 2'd0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inst_wen,
    input  logic [31:0]                  inst_wdata,
    input  logic [DESTW-1:0]             inst_wdest,
    input  logic                         inst_wlast,
    output logic                         inst_wrdy,
    input  logic                         clear,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   sent_count,
    output logic                         axis_tx_tvalid,
    input  logic                         axis_tx_tready,
    output logic [DATAW+USERW-1:0]       axis_tx_tdata,
    output logic [IDW-1:0]               axis_tx_tid,
    output logic [DESTW-1:0]             axis_tx_tdest,
    output logic                         axis_tx_tlast
);

    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned ENTW = 32 + DESTW + 1;
    localparam int unsigned TW   = DATAW + USERW;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [1:0]      state_q, state_d;
    logic [ENTW-1:0] mem_q [DEPTH];
    logic [CNTW-1:0] count_q, count_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] sent_q, sent_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [TW-1:0]   tdata_q, tdata_d;
    logic [DESTW-1:0] tdest_q, tdest_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wrdy_q, wrdy_d;

    logic            wr_fire_s;
    logic [ENTW-1:0] wr_entry_s;
    logic [PTRW-1:0] start_idx_s;
    logic            ld_en_s;
    logic [ENTW-1:0] ld_entry_s;
    logic            last_pop_s;

    function automatic logic [TW-1:0] pack_flit(input logic [31:0] inst);
        logic [USERW-1:0] user;
        user       = '0;
        user[10:9] = INST_TYPE;
        return {user, {(DATAW-32){1'b0}}, inst};
    endfunction

    assign wr_entry_s = {inst_wdata, inst_wdest, inst_wlast};
`ifdef INST_LOADER_REPLAY_EN
    // Replay restarts the read pointer at entry 0 for every stream.
    assign start_idx_s = '0;
`else
    assign start_idx_s = rd_ptr_q;
`endif

    // Next-state, buffer bookkeeping and output-stage load selection.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sent_d     = sent_q;
        tvalid_d   = tvalid_q;
        wr_fire_s  = 1'b0;
        ld_en_s    = 1'b0;
        ld_entry_s = '0;
        last_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else begin
                    if (inst_wen && wrdy_q) begin
                        wr_fire_s = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_ONE;
                        count_d   = count_q + CNT_ONE;
                    end else begin
                        wr_fire_s = 1'b0;
                    end
                    if (start) begin
                        sent_d = '0;
                        if (count_d != '0) begin
                            state_d  = ST_STREAM;
                            tvalid_d = 1'b1;
                            rd_ptr_d = start_idx_s;
                            ld_en_s  = 1'b1;
                            // An empty buffer means the first flit is the word being written now.
                            ld_entry_s = (count_q == '0) ? wr_entry_s : mem_q[start_idx_s];
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STREAM: begin
                if (tvalid_q && axis_tx_tready) begin
                    sent_d   = sent_q + CNT_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef INST_LOADER_REPLAY_EN
                    last_pop_s = ((sent_q + CNT_ONE) == count_q);
`else
                    count_d    = count_q - CNT_ONE;
                    last_pop_s = (count_q == CNT_ONE);
`endif
                    if (last_pop_s) begin
                        tvalid_d = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        ld_en_s    = 1'b1;
                        ld_entry_s = mem_q[rd_ptr_q + PTR_ONE];
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
            end
        endcase

        if (ld_en_s) begin
            tdata_d = pack_flit(ld_entry_s[ENTW-1 -: 32]);
            tdest_d = ld_entry_s[DESTW:1];
            tlast_d = ld_entry_s[0];
        end else begin
            tdata_d = tdata_q;
            tdest_d = tdest_q;
            tlast_d = tlast_q;
        end

        wrdy_d = (state_d == ST_IDLE) && (count_d < CNT_FULL);
        busy_d = (state_d == ST_STREAM);
        done_d = (state_d == ST_DONE);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sent_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tdest_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrdy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sent_q   <= sent_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tdest_q  <= tdest_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrdy_q   <= wrdy_d;
        end
    end

    // Instruction buffer storage.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

    assign inst_wrdy      = wrdy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign sent_count     = sent_q;
    assign axis_tx_tvalid = tvalid_q;
    assign axis_tx_tdata  = tdata_q;
    assign axis_tx_tid    = IDW'(TID);
    assign axis_tx_tdest  = tdest_q;
    assign axis_tx_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_inst_loader.sv
// Directed self-checking bench for axis_inst_loader (default parameters; honours INST_LOADER_REPLAY_EN).
module tb_axis_inst_loader;

    localparam int DATAW = 512;
    localparam int USERW = 75;
    localparam int TW    = DATAW + USERW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            inst_wen;
    logic [31:0]     inst_wdata;
    logic [3:0]      inst_wdest;
    logic            inst_wlast;
    logic            inst_wrdy;
    logic            clear;
    logic            start;
    logic            busy;
    logic            done;
    logic [8:0]      sent_count;
    logic            axis_tx_tvalid;
    logic            axis_tx_tready;
    logic [TW-1:0]   axis_tx_tdata;
    logic [1:0]      axis_tx_tid;
    logic [3:0]      axis_tx_tdest;
    logic            axis_tx_tlast;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_dest[$];
    logic        q_last[$];

    always #5 clk = ~clk;

    axis_inst_loader dut (
        .clk(clk), .rst_n(rst_n),
        .inst_wen(inst_wen), .inst_wdata(inst_wdata), .inst_wdest(inst_wdest),
        .inst_wlast(inst_wlast), .inst_wrdy(inst_wrdy),
        .clear(clear), .start(start), .busy(busy), .done(done), .sent_count(sent_count),
        .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready),
        .axis_tx_tdata(axis_tx_tdata), .axis_tx_tid(axis_tx_tid),
        .axis_tx_tdest(axis_tx_tdest), .axis_tx_tlast(axis_tx_tlast)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_entry(input logic [31:0] d, input logic [3:0] dst, input logic lst);
        inst_wen = 1'b1; inst_wdata = d; inst_wdest = dst; inst_wlast = lst;
        step();
        inst_wen = 1'b0;
        q_data.push_back(d); q_dest.push_back(dst); q_last.push_back(lst);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Replay keeps old programs, so empty the buffer between independent tests.
    task automatic prep();
`ifdef INST_LOADER_REPLAY_EN
        do_clear();
`else
        step();
`endif
    endtask

    task automatic do_start(input bit with_wr, input logic [31:0] d, input logic [3:0] dst,
                            input logic lst, input logic exp_tvalid, input string tag);
        start = 1'b1;
        if (with_wr) begin
            inst_wen = 1'b1; inst_wdata = d; inst_wdest = dst; inst_wlast = lst;
            q_data.push_back(d); q_dest.push_back(dst); q_last.push_back(lst);
        end
        step();
        start = 1'b0; inst_wen = 1'b0;
        check_val({tag, "_tvalid"}, 64'(axis_tx_tvalid), 64'(exp_tvalid));
    endtask

    task automatic expect_empty_done(input string tag);
        check_val({tag, "_done"}, 64'(done), 64'd1);
        check_val({tag, "_sent"}, 64'(sent_count), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    function automatic logic ready_at(input int pat, input int cyc);
        logic [5:0] p;
        p = 6'b101001;
        if (pat == 1 && cyc < 6) return p[cyc];
        return 1'b1;
    endfunction

    // Observes one stream already started; compares every accepted flit against the expected queue.
    task automatic run_stream(input string tag, input int pat, input int budget, input bit keep);
        int idx = 0;
        int cyc = 0;
        int last_hs = -10;
        int done_cyc = -1;
        bit done_seen = 0;
        bit hold = 0;
        logic [31:0] pd;
        logic [3:0]  pdest;
        logic        plast;
        int n_exp = q_data.size();
        while (!done_seen && cyc < budget) begin
            axis_tx_tready = ready_at(pat, cyc);
            if (hold && axis_tx_tvalid) begin
                check_val($sformatf("%s_hold_data%0d", tag, cyc), 64'(axis_tx_tdata[31:0]), 64'(pd));
                check_val($sformatf("%s_hold_dest%0d", tag, cyc), 64'(axis_tx_tdest), 64'(pdest));
                check_val($sformatf("%s_hold_last%0d", tag, cyc), 64'(axis_tx_tlast), 64'(plast));
            end
            if (axis_tx_tvalid && axis_tx_tready) begin
                if (idx < n_exp) begin
                    check_val($sformatf("%s_data%0d", tag, idx), 64'(axis_tx_tdata[31:0]), 64'(q_data[idx]));
                    check_val($sformatf("%s_dest%0d", tag, idx), 64'(axis_tx_tdest), 64'(q_dest[idx]));
                    check_val($sformatf("%s_last%0d", tag, idx), 64'(axis_tx_tlast), 64'(q_last[idx]));
                    check_val($sformatf("%s_hi%0d", tag, idx), 64'(|axis_tx_tdata[TW-1:32]), 64'd0);
                end else begin
                    check_val($sformatf("%s_extra_flit%0d", tag, idx), 64'(idx), 64'(n_exp - 1));
                end
                idx++;
                last_hs = cyc;
                hold = 1'b0;
            end else if (axis_tx_tvalid) begin
                hold = 1'b1;
                pd = axis_tx_tdata[31:0]; pdest = axis_tx_tdest; plast = axis_tx_tlast;
            end else begin
                hold = 1'b0;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc = cyc;
            end else begin
                step();
                cyc++;
            end
        end
        check_val({tag, "_done_seen"}, 64'(done_seen), 64'd1);
        check_val({tag, "_nflits"}, 64'(idx), 64'(n_exp));
        check_val({tag, "_done_lat"}, 64'(done_cyc - last_hs), 64'd1);
        check_val({tag, "_sent"}, 64'(sent_count), 64'(n_exp));
        step();
        check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_val({tag, "_sent_hold"}, 64'(sent_count), 64'(n_exp));
        if (!keep) begin
            q_data.delete(); q_dest.delete(); q_last.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; inst_wen = 1'b0; inst_wdata = '0; inst_wdest = '0; inst_wlast = 1'b0;
        clear = 1'b0; start = 1'b0; axis_tx_tready = 1'b0;
        #12;
        check_val("rst_tvalid", 64'(axis_tx_tvalid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_sent", 64'(sent_count), 64'd0);
        check_val("rst_wrdy", 64'(inst_wrdy), 64'd1);
        check_val("rst_tid", 64'(axis_tx_tid), 64'd0);
        check_val("rst_tdata", 64'(|axis_tx_tdata), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic three-flit program, tready held high.
        axis_tx_tready = 1'b1;
        wr_entry(32'hA000_0001, 4'd2, 1'b0);
        wr_entry(32'h0000_0002, 4'd2, 1'b1);
        wr_entry(32'h8040_0010, 4'd14, 1'b1);
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, "t1_first");
        check_val("t1_busy", 64'(busy), 64'd1);
        check_val("t1_wrdy", 64'(inst_wrdy), 64'd0);
        run_stream("t1", 0, 20, 1'b0);

        // Same program with back-pressure.
        prep();
        wr_entry(32'hA000_0001, 4'd2, 1'b0);
        wr_entry(32'h0000_0002, 4'd2, 1'b1);
        wr_entry(32'h8040_0010, 4'd14, 1'b1);
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, "t2_first");
        run_stream("t2", 1, 30, 1'b0);

        // Start on empty buffer, then start with a same-cycle write.
        prep();
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, "t3_empty");
        expect_empty_done("t3_empty");
        step();
        check_val("t3_empty_pulse", 64'(done), 64'd0);
        do_start(1'b1, 32'h1234_5678, 4'd7, 1'b1, 1'b1, "t3_samecyc");
        run_stream("t3_samecyc", 0, 20, 1'b0);

        // Fill to capacity; the extra write must be dropped.
        prep();
        for (int i = 0; i < 256; i++) begin
            wr_entry(32'h1000_0000 + 32'(i), 4'(i % 16), 1'((i % 8) == 7));
        end
        check_val("t4_full_wrdy", 64'(inst_wrdy), 64'd0);
        inst_wen = 1'b1; inst_wdata = 32'hDEAD_BEEF; inst_wdest = 4'd9; inst_wlast = 1'b1;
        step();
        inst_wen = 1'b0;
        check_val("t4_still_full", 64'(inst_wrdy), 64'd0);
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, "t4_first");
        run_stream("t4", 0, 400, 1'b0);

        // Clear beats a simultaneous write and start.
        prep();
        wr_entry(32'h0000_00AA, 4'd1, 1'b1);
        wr_entry(32'h0000_00BB, 4'd1, 1'b1);
        clear = 1'b1; start = 1'b1; inst_wen = 1'b1; inst_wdata = 32'h0000_00CC;
        step();
        clear = 1'b0; start = 1'b0; inst_wen = 1'b0;
        q_data.delete(); q_dest.delete(); q_last.delete();
        check_val("t5_busy", 64'(busy), 64'd0);
        check_val("t5_done", 64'(done), 64'd0);
        check_val("t5_tvalid", 64'(axis_tx_tvalid), 64'd0);
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, "t5_after");
        expect_empty_done("t5_after");
        step();

        // Second start: replay re-sends, consume mode finds an empty buffer.
        prep();
        wr_entry(32'h0000_0101, 4'd3, 1'b0);
        wr_entry(32'h0000_0202, 4'd3, 1'b1);
        wr_entry(32'h0000_0303, 4'd5, 1'b0);
        wr_entry(32'h0000_0404, 4'd5, 1'b1);
`ifdef INST_LOADER_REPLAY_EN
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, "t6_a");
        run_stream("t6_a", 0, 20, 1'b1);
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, "t6_b");
        run_stream("t6_b", 1, 30, 1'b0);
        do_clear();
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, "t6_clr");
        expect_empty_done("t6_clr");
`else
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, "t6_a");
        run_stream("t6_a", 0, 20, 1'b0);
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, "t6_b");
        expect_empty_done("t6_b");
`endif
        step();

        // Asynchronous reset in the middle of a stream.
        prep();
        for (int i = 0; i < 5; i++) begin
            wr_entry(32'h0000_5000 + 32'(i), 4'd4, 1'b1);
        end
        axis_tx_tready = 1'b1;
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, "t7_first");
        step();
        step();
        check_val("t7_pre_tvalid", 64'(axis_tx_tvalid), 64'd1);
        check_val("t7_pre_sent", 64'(sent_count), 64'd2);
        check_val("t7_pre_data", 64'(axis_tx_tdata[31:0]), 64'h0000_5002);
        rst_n = 1'b0;
        #1;
        check_val("t7_rst_tvalid", 64'(axis_tx_tvalid), 64'd0);
        check_val("t7_rst_busy", 64'(busy), 64'd0);
        check_val("t7_rst_sent", 64'(sent_count), 64'd0);
        #2;
        rst_n = 1'b1;
        q_data.delete(); q_dest.delete(); q_last.delete();
        step();
        check_val("t7_post_busy", 64'(busy), 64'd0);
        check_val("t7_post_wrdy", 64'(inst_wrdy), 64'd1);
        do_start(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, "t7_empty");
        expect_empty_done("t7_empty");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
